divider_prog: RTL

Programmable integer clock divider: the run-time-configurable successor to the team's fixed-ratio dividers. It divides `i_clk` by a ratio N (2 … 2^WIDTH−1) selected at run time and produces a registered divided clock with near-50% duty cycle. It also produces a one-cycle period tick, for use as a clock-enable in the `i_clk` domain. Ratio changes are double-buffered and take effect only on a period boundary, so the output never glitches or produces a runt period.

---
 rtl/divider_prog.sv | 81 ++++++++
 1 files changed

// File: rtl/divider_prog.sv
// Programmable integer clock divider with double-buffered ratio, period tick
// and load handshake. All outputs are registered from next-state values.
module divider_prog #(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 6
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_div,
  output logic             o_div_clk,
  output logic             o_tick,
  output logic             o_load_ack,
  output logic             o_load_err,
  output logic             o_busy,
  output logic [WIDTH-1:0] o_div_cur
);

  localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);

  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_div;
  logic [WIDTH-1:0] r_pend;
  logic             r_pend_v;

  logic             w_wrap;
  logic             w_swap;
  logic             w_load_ok;
  logic             w_load_bad;
  logic [WIDTH-1:0] w_cnt_nxt;
  logic [WIDTH-1:0] w_div_nxt;
  logic [WIDTH:0]   w_high;

  assign w_wrap     = i_en && (r_cnt == r_div - 1'b1);
  assign w_swap     = w_wrap && r_pend_v;
  assign w_load_ok  = i_load && (i_div >= WIDTH'(2));
  assign w_load_bad = i_load && (i_div <  WIDTH'(2));
  assign w_div_nxt  = w_swap ? r_pend : r_div;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (!i_en)       w_cnt_nxt = r_div - 1'b1;
    else if (w_wrap) w_cnt_nxt = '0;
    else             w_cnt_nxt = r_cnt + 1'b1;
  end

  // High time ceil(div/2) computed one bit wider so div = 2^WIDTH-1 cannot overflow.
  assign w_high = ({1'b0, w_div_nxt} + 1'b1) >> 1;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt      <= DEF_DIV - 1'b1;
      r_div      <= DEF_DIV;
      r_pend     <= DEF_DIV;
      r_pend_v   <= 1'b0;
      o_div_clk  <= 1'b0;
      o_tick     <= 1'b0;
      o_load_ack <= 1'b0;
      o_load_err <= 1'b0;
    end else begin
      r_cnt      <= w_cnt_nxt;
      r_div      <= w_div_nxt;
      o_div_clk  <= i_en && ({1'b0, w_cnt_nxt} < w_high);
      o_tick     <= i_en && (w_cnt_nxt == '0);
      o_load_ack <= w_swap;
      o_load_err <= w_load_bad;
      // A load coinciding with a wrap becomes pending after the wrap consumed the old one.
      if (w_load_ok) begin
        r_pend   <= i_div;
        r_pend_v <= 1'b1;
      end else if (w_swap) begin
        r_pend_v <= 1'b0;
      end
    end
  end

  assign o_busy    = r_pend_v;
  assign o_div_cur = r_div;

endmodule
